// File: rtl/gcd_arbiter_pkg.sv
// Shared types and constants for the GCD arbiter: FSM state encoding,
// default datapath width and the watchdog timer width.
package gcd_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  localparam int DEFAULT_W = 8;
  localparam int TIMER_W   = 8;

  // Increment with wrap at n; used for the round-robin pointer.
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/gcd_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit at or after ptr,
// wrapping at N. Produces both one-hot and index forms of the winner.
module gcd_arbiter_rr_pick
  import gcd_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW:0]   sum;
  logic [IW-1:0] cand;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    sum    = '0;
    cand   = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(N)) begin
        sum = sum - (IW+1)'(N);
      end
      cand = sum[IW-1:0];
      if (!any && req[cand]) begin
        any          = 1'b1;
        idx          = cand;
        onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gcd_arbiter.sv
// Shares a single GCD datapath between N_REQ requesters with round-robin
// arbitration, operand capture, START sequencing and a hang watchdog.
module gcd_arbiter
  import gcd_arbiter_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int W       = DEFAULT_W,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [W-1:0]       rsp_y,
  output logic               rsp_err,
  output logic               rsp_timeout,
  output logic               busy,
  output logic [W-1:0]       gcd_a,
  output logic [W-1:0]       gcd_b,
  output logic               gcd_start,
  input  logic [W-1:0]       gcd_y,
  input  logic               gcd_done,
  input  logic               gcd_error
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  arb_state_t         state, state_next;
  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      owner;
  logic [N_REQ-1:0]   owner_oh;
  logic [W-1:0]       op_a, op_b;
  logic [W-1:0]       res_y;
  logic               res_err, res_to;
  logic [TIMER_W-1:0] timer;

  logic [N_REQ-1:0]   pick_oh;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;
  logic [W-1:0]       sel_a, sel_b;

  gcd_arbiter_rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req    (req),
    .ptr    (rr_ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_oh[i]) begin
        sel_a = req_a[i*W +: W];
        sel_b = req_b[i*W +: W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operand/result capture and watchdog; DONE takes priority over expiry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      owner    <= '0;
      owner_oh <= '0;
      op_a     <= '0;
      op_b     <= '0;
      res_y    <= '0;
      res_err  <= 1'b0;
      res_to   <= 1'b0;
      timer    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            owner    <= pick_idx;
            owner_oh <= pick_oh;
            op_a     <= sel_a;
            op_b     <= sel_b;
          end
        end
        ST_ISSUE: begin
          timer <= '0;
        end
        ST_WAIT: begin
          if (gcd_done) begin
            res_y   <= gcd_y;
            res_err <= gcd_error;
            res_to  <= 1'b0;
          end else if (timer == TIMER_LAST) begin
            res_y   <= '0;
            res_err <= 1'b1;
            res_to  <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_RESP: begin
          rr_ptr <= IW'(wrap_inc(int'(owner), N_REQ));
        end
        default: ;
      endcase
    end
  end

  assign gcd_a = op_a;
  assign gcd_b = op_b;

  always_comb begin
    state_next  = state;
    gnt         = '0;
    rsp_valid   = '0;
    rsp_y       = '0;
    rsp_err     = 1'b0;
    rsp_timeout = 1'b0;
    gcd_start   = 1'b0;
    busy        = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (pick_any) begin
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        gnt        = owner_oh;
        gcd_start  = 1'b1;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (gcd_done || (timer == TIMER_LAST)) begin
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid   = owner_oh;
        rsp_y       = res_y;
        rsp_err     = res_err;
        rsp_timeout = res_to;
        state_next  = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_gcd_arbiter.sv
// Self-checking bench for gcd_arbiter with a behavioural GCD whose DONE
// appears a programmable number of WAIT cycles after START.
`timescale 1ns/1ps
module tb_gcd_arbiter;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int TMO = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_a, req_b;
  logic [N-1:0]   gnt, rsp_valid;
  logic [W-1:0]   rsp_y;
  logic           rsp_err, rsp_timeout, busy;
  logic [W-1:0]   gcd_a, gcd_b;
  logic           gcd_start;
  logic [W-1:0]   gcd_y;
  logic           gcd_done, gcd_error;

  logic [W-1:0] op_a [N];
  logic [W-1:0] op_b [N];

  int n_checks = 0;
  int n_fail   = 0;
  int exp_ptr  = 0;

  // Behavioural GCD: m_lat = WAIT cycles before DONE, m_never suppresses DONE.
  int         m_lat = 0;
  bit         m_never = 1'b0;
  logic       m_extra_done = 1'b0;
  logic       m_act = 1'b0;
  int         m_cnt = 0;
  logic [7:0] m_a = 8'd0;
  logic [7:0] m_b = 8'd0;

  function automatic logic [7:0] ref_gcd(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] x, y, t;
    x = a;
    y = b;
    while (y != 8'd0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic int pick(input logic [3:0] m, input int p);
    int idx;
    for (int k = 0; k < N; k++) begin
      idx = (p + k) % N;
      if (m[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  assign req_a = {op_a[3], op_a[2], op_a[1], op_a[0]};
  assign req_b = {op_b[3], op_b[2], op_b[1], op_b[0]};

  assign gcd_error = (m_a == 8'd0) || (m_b == 8'd0);
  assign gcd_y     = gcd_error ? 8'd0 : ref_gcd(m_a, m_b);
  assign gcd_done  = (m_act && !m_never && (m_cnt == m_lat)) || m_extra_done;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_act <= 1'b0;
    end else if (gcd_start) begin
      m_act <= 1'b1;
      m_cnt <= 0;
      m_a   <= gcd_a;
      m_b   <= gcd_b;
    end else if (m_act) begin
      if (gcd_done) m_act <= 1'b0;
      m_cnt <= m_cnt + 1;
    end
  end

  always #5 clk = ~clk;

  gcd_arbiter #(.N_REQ(N), .W(W), .TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_a       (req_a),
    .req_b       (req_b),
    .gnt         (gnt),
    .rsp_valid   (rsp_valid),
    .rsp_y       (rsp_y),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .busy        (busy),
    .gcd_a       (gcd_a),
    .gcd_b       (gcd_b),
    .gcd_start   (gcd_start),
    .gcd_y       (gcd_y),
    .gcd_done    (gcd_done),
    .gcd_error   (gcd_error)
  );

  // Steps negedges from the current one, recording the first grant and the
  // response; cycle numbers count edges since the call. -1 means never seen.
  task automatic run_txn(input bit hold, output int gc, output logic [3:0] g,
                         output int rc, output logic [3:0] rv, output logic [7:0] y,
                         output logic err, output logic to);
    gc = -1; rc = -1; g = '0; rv = '0; y = '0; err = 1'b0; to = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (gc < 0 && |gnt) begin
        gc = c;
        g  = gnt;
        if (!hold) req = req & ~gnt;
      end
      if (|rsp_valid) begin
        rc = c; rv = rsp_valid; y = rsp_y; err = rsp_err; to = rsp_timeout;
        break;
      end
    end
  endtask

  task automatic randomize_ops();
    for (int i = 0; i < N; i++) begin
      op_a[i] = 8'($urandom_range(1, 255));
      op_b[i] = 8'($urandom_range(1, 255));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    randomize_ops();
    req = 4'b1111;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({gnt, rsp_valid, rsp_y, rsp_err, rsp_timeout, busy, gcd_a, gcd_b, gcd_start} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got gnt=%b rv=%b y=%h busy=%b start=%b a=%h b=%h, expected all 0",
               gnt, rsp_valid, rsp_y, busy, gcd_start, gcd_a, gcd_b);
    end
    req = '0;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_idle: got busy=%b expected 0", busy);
    end
    exp_ptr = 0;
  endtask

  task automatic test_basic();
    int gc, rc; logic [3:0] g, rv; logic [7:0] y; logic err, to;
    m_lat = 5;
    op_a[0] = 8'd48;
    op_b[0] = 8'd18;
    req = 4'b0001;
    run_txn(1'b0, gc, g, rc, rv, y, err, to);
    n_checks++;
    if (gc !== 1 || g !== 4'b0001) begin
      n_fail++;
      $display("[TB] FAIL basic_gnt: got cycle %0d gnt=%b expected cycle 1 gnt=0001", gc, g);
    end
    n_checks++;
    if (rc !== 8 || rv !== 4'b0001 || y !== 8'd6 || err !== 1'b0 || to !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL basic_rsp: got cycle %0d rv=%b y=%0d err=%b to=%b expected cycle 8 rv=0001 y=6 err=0 to=0",
               rc, rv, y, err, to);
    end
    @(negedge clk);
    n_checks++;
    if ({rsp_valid, rsp_y, rsp_err, rsp_timeout, busy} !== '0) begin
      n_fail++;
      $display("[TB] FAIL basic_after: got rv=%b y=%h err=%b to=%b busy=%b expected all 0",
               rsp_valid, rsp_y, rsp_err, rsp_timeout, busy);
    end
    exp_ptr = 1;
  endtask

  task automatic test_random_single();
    int gc, rc, i, lat; logic [3:0] g, rv, e; logic [7:0] y; logic err, to;
    for (int n = 0; n < 6; n++) begin
      i   = $urandom_range(0, N-1);
      lat = $urandom_range(0, TMO-2);
      m_lat = lat;
      randomize_ops();
      e = 4'b0001 << i;
      req = e;
      run_txn(1'b0, gc, g, rc, rv, y, err, to);
      n_checks++;
      if (gc !== 1 || g !== e || rc !== lat + 3 || rv !== e) begin
        n_fail++;
        $display("[TB] FAIL single_timing: got gnt %b@%0d rsp %b@%0d expected %b@1 %b@%0d",
                 g, gc, rv, rc, e, e, lat + 3);
      end
      n_checks++;
      if (y !== ref_gcd(op_a[i], op_b[i]) || err !== 1'b0 || to !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL single_result: got y=%0d err=%b to=%b expected y=%0d err=0 to=0",
                 y, err, to, ref_gcd(op_a[i], op_b[i]));
      end
      @(negedge clk);
      exp_ptr = (i + 1) % N;
    end
  endtask

  task automatic test_error();
    int gc, rc; logic [3:0] g, rv; logic [7:0] y; logic err, to;
    m_lat = 3;
    op_a[2] = 8'd0;
    op_b[2] = 8'd0;
    req = 4'b0100;
    run_txn(1'b0, gc, g, rc, rv, y, err, to);
    n_checks++;
    if (rc !== 6 || rv !== 4'b0100 || err !== 1'b1 || to !== 1'b0 || y !== 8'd0) begin
      n_fail++;
      $display("[TB] FAIL error_rsp: got cycle %0d rv=%b y=%0d err=%b to=%b expected cycle 6 rv=0100 y=0 err=1 to=0",
               rc, rv, y, err, to);
    end
    @(negedge clk);
    exp_ptr = 3;
  endtask

  task automatic test_reset_mid();
    int gc, rc; logic [3:0] g, rv; logic [7:0] y; logic err, to;
    bit seen;
    m_lat = 6;
    randomize_ops();
    req = 4'b0001;
    @(negedge clk);
    req = '0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if ({gnt, rsp_valid, rsp_y, rsp_err, rsp_timeout, busy, gcd_a, gcd_b, gcd_start} !== '0) begin
      n_fail++;
      $display("[TB] FAIL midreset_outputs: got gnt=%b rv=%b busy=%b a=%h b=%h expected all 0",
               gnt, rsp_valid, busy, gcd_a, gcd_b);
    end
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (|rsp_valid || busy) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL midreset_quiet: got activity=%b expected 0", seen);
    end
    exp_ptr = 0;
    m_lat = 2;
    req = 4'b0011;
    run_txn(1'b0, gc, g, rc, rv, y, err, to);
    n_checks++;
    if (g !== 4'b0001 || rv !== 4'b0001 || y !== ref_gcd(op_a[0], op_b[0])) begin
      n_fail++;
      $display("[TB] FAIL midreset_first: got gnt=%b rv=%b y=%0d expected 0001 0001 %0d",
               g, rv, y, ref_gcd(op_a[0], op_b[0]));
    end
    run_txn(1'b0, gc, g, rc, rv, y, err, to);
    n_checks++;
    if (gc !== 2 || g !== 4'b0010 || rv !== 4'b0010 || y !== ref_gcd(op_a[1], op_b[1])) begin
      n_fail++;
      $display("[TB] FAIL midreset_second: got gnt=%b@%0d rv=%b y=%0d expected 0010@2 0010 %0d",
               g, gc, rv, y, ref_gcd(op_a[1], op_b[1]));
    end
    @(negedge clk);
    exp_ptr = 2;
  endtask

  task automatic test_timeout();
    int gc, rc, i; logic [3:0] g, rv, e; logic [7:0] y; logic err, to;
    bit seen;
    i = $urandom_range(0, N-1);
    e = 4'b0001 << i;
    randomize_ops();
    m_never = 1'b1;
    req = e;
    run_txn(1'b0, gc, g, rc, rv, y, err, to);
    n_checks++;
    if (gc !== 1 || rc !== TMO + 2 || rv !== e) begin
      n_fail++;
      $display("[TB] FAIL timeout_timing: got gnt@%0d rsp %b@%0d expected gnt@1 rsp %b@%0d",
               gc, rv, rc, e, TMO + 2);
    end
    n_checks++;
    if (to !== 1'b1 || err !== 1'b1 || y !== 8'd0) begin
      n_fail++;
      $display("[TB] FAIL timeout_flags: got to=%b err=%b y=%0d expected to=1 err=1 y=0", to, err, y);
    end
    exp_ptr = (i + 1) % N;
    repeat (2) @(negedge clk);
    m_extra_done = 1'b1;
    @(negedge clk);
    m_extra_done = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (busy || |rsp_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL late_done: got activity=%b expected 0", seen);
    end
    m_never = 1'b0;
  endtask

  task automatic test_coincide();
    int gc, rc, i; logic [3:0] g, rv, e; logic [7:0] y; logic err, to;
    i = $urandom_range(0, N-1);
    e = 4'b0001 << i;
    randomize_ops();
    m_lat = TMO - 1;
    req = e;
    run_txn(1'b0, gc, g, rc, rv, y, err, to);
    n_checks++;
    if (rc !== TMO + 2 || rv !== e || to !== 1'b0 || err !== 1'b0 || y !== ref_gcd(op_a[i], op_b[i])) begin
      n_fail++;
      $display("[TB] FAIL coincide: got %b@%0d y=%0d err=%b to=%b expected %b@%0d y=%0d err=0 to=0",
               rv, rc, y, err, to, e, TMO + 2, ref_gcd(op_a[i], op_b[i]));
    end
    @(negedge clk);
    exp_ptr = (i + 1) % N;
    m_lat = TMO;
    req = e;
    run_txn(1'b0, gc, g, rc, rv, y, err, to);
    n_checks++;
    if (rc !== TMO + 2 || to !== 1'b1 || err !== 1'b1 || y !== 8'd0) begin
      n_fail++;
      $display("[TB] FAIL one_late: got rsp@%0d y=%0d err=%b to=%b expected rsp@%0d y=0 err=1 to=1",
               rc, y, err, to, TMO + 2);
    end
    @(negedge clk);
  endtask

  task automatic test_random_multi();
    int gc, rc, w; logic [3:0] g, rv, e, mask; logic [7:0] y; logic err, to;
    for (int r = 0; r < 4; r++) begin
      randomize_ops();
      mask = 4'($urandom_range(1, 15));
      while (mask != 4'b0000) begin
        m_lat = $urandom_range(0, 4);
        w = pick(mask, exp_ptr);
        e = 4'b0001 << w;
        req = mask;
        run_txn(1'b0, gc, g, rc, rv, y, err, to);
        n_checks++;
        if (g !== e || rv !== e || y !== ref_gcd(op_a[w], op_b[w]) || err !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL rr_multi: got gnt=%b rv=%b y=%0d err=%b expected %b %b y=%0d err=0",
                   g, rv, y, err, e, e, ref_gcd(op_a[w], op_b[w]));
        end
        mask = mask & ~e;
        exp_ptr = (w + 1) % N;
      end
      req = '0;
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int gc, rc, w; logic [3:0] g, rv, e; logic [7:0] y; logic err, to;
    rst_n = 1'b0;
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    randomize_ops();
    m_lat = 1;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      w = k % N;
      e = 4'b0001 << w;
      run_txn(1'b1, gc, g, rc, rv, y, err, to);
      n_checks++;
      if (g !== e || rv !== e || gc !== ((k == 0) ? 1 : 2) || y !== ref_gcd(op_a[w], op_b[w])) begin
        n_fail++;
        $display("[TB] FAIL b2b_%0d: got gnt=%b@%0d rv=%b y=%0d expected %b@%0d %b y=%0d",
                 k, g, gc, rv, y, e, (k == 0) ? 1 : 2, e, ref_gcd(op_a[w], op_b[w]));
      end
    end
    req = '0;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    req = '0;
    for (int i = 0; i < N; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    test_reset();
    test_basic();
    test_random_single();
    test_error();
    test_reset_mid();
    test_timeout();
    test_coincide();
    test_random_multi();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
